// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Receives a count-prefixed big-endian byte stream, writes it into
//            instruction memory, then releases the processor from reset.
// Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [2:0]  c_CNT_HI = 3'd0;
    localparam logic [2:0]  c_CNT_LO = 3'd1;
    localparam logic [2:0]  c_DAT_HI = 3'd2;
    localparam logic [2:0]  c_DAT_LO = 3'd3;
    localparam logic [2:0]  c_WRITE  = 3'd4;
    localparam logic [2:0]  c_RUN    = 3'd5;
    localparam logic [2:0]  c_ERROR  = 3'd6;

    localparam logic [16:0] c_DEPTH  = 17'(2 ** ADDR_W);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [15:0]       r_count;
    logic [ADDR_W-1:0] r_index;
    logic [15:0]       r_wdata;
    logic              r_imem_we;
    logic              r_cpu_reset;
    logic              r_load_done;
    logic              r_load_error;

    logic              w_rx_ready;
    logic              w_accept;
    logic [15:0]       w_count_full;
    logic              w_last;

    assign w_rx_ready   = (r_state == c_CNT_HI) || (r_state == c_CNT_LO) ||
                          (r_state == c_DAT_HI) || (r_state == c_DAT_LO);
    assign w_accept     = rx_valid & w_rx_ready;
    assign w_count_full = {r_count[15:8], rx_data};
    // Word index is zero-extended; the count never exceeds DEPTH so this is exact.
    assign w_last       = ((16'(r_index) + 16'd1) == r_count);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_CNT_HI: if (w_accept) w_state_nxt = c_CNT_LO;
            c_CNT_LO: begin
                if (w_accept) begin
                    if (w_count_full == 16'd0)
                        w_state_nxt = c_RUN;
                    else if ({1'b0, w_count_full} > c_DEPTH)
                        w_state_nxt = c_ERROR;
                    else
                        w_state_nxt = c_DAT_HI;
                end
            end
            c_DAT_HI: if (w_accept) w_state_nxt = c_DAT_LO;
            c_DAT_LO: if (w_accept) w_state_nxt = c_WRITE;
            c_WRITE:  w_state_nxt = w_last ? c_RUN : c_DAT_HI;
            c_RUN:    w_state_nxt = c_RUN;
            c_ERROR:  w_state_nxt = c_ERROR;
            default:  w_state_nxt = c_CNT_HI;
        endcase
        if (reload)
            w_state_nxt = c_CNT_HI;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_CNT_HI;
            r_count      <= 16'd0;
            r_index      <= '0;
            r_wdata      <= 16'd0;
            r_imem_we    <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cpu_reset  <= (w_state_nxt != c_RUN);
            r_load_done  <= (w_state_nxt == c_RUN);
            r_load_error <= (w_state_nxt == c_ERROR);
            // A low data byte arriving together with reload is discarded, so no write.
            r_imem_we    <= (r_state == c_DAT_LO) && w_accept && !reload;
            if (reload) begin
                r_count <= 16'd0;
                r_index <= '0;
            end else begin
                case (r_state)
                    c_CNT_HI: if (w_accept) r_count[15:8] <= rx_data;
                    c_CNT_LO: if (w_accept) r_count[7:0]  <= rx_data;
                    c_DAT_HI: if (w_accept) r_wdata[15:8] <= rx_data;
                    c_DAT_LO: if (w_accept) r_wdata[7:0]  <= rx_data;
                    // Holding the index on the final word keeps the address from wrapping.
                    c_WRITE:  if (!w_last)  r_index       <= r_index + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready   = w_rx_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_index;
    assign imem_wdata = r_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Self-checking bench for imem_boot_loader against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_valid = 1'b0;
    logic              reload   = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_error;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Stream-level model: bytes seen so far in this load decide everything.
    int          m_mode;
    int          m_bytes;
    int          m_n;
    logic [15:0] m_data;
    int          m_addr;
    bit          m_wr;

    int          wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          last_we_cyc  = 0;
    int          last_acc_cyc = 0;
    int          fall_cyc     = 0;
    logic        prev_cpu_reset = 1'b1;
    logic [15:0] words[DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_ready();
        return (m_mode == M_LOAD) && !m_wr;
    endfunction

    task automatic model_reset();
        m_mode = M_LOAD; m_bytes = 0; m_n = 0; m_data = 16'h0; m_addr = 0; m_wr = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
            return;
        end
        if (reload) begin
            m_mode = M_LOAD; m_bytes = 0; m_n = 0; m_addr = 0; m_wr = 0;
            return;
        end
        if (m_wr) begin
            m_wr = 0;
            if (m_addr + 1 == m_n) m_mode = M_RUN;
            return;
        end
        if (m_mode == M_LOAD && rx_valid) begin
            if (m_bytes == 0) begin
                m_n = int'(rx_data) * 256;
            end else if (m_bytes == 1) begin
                m_n = m_n + int'(rx_data);
                if (m_n == 0)         m_mode = M_RUN;
                else if (m_n > DEPTH) m_mode = M_ERR;
            end else if (m_bytes % 2 == 0) begin
                m_data = {rx_data, 8'h00};
            end else begin
                m_data[7:0] = rx_data;
                m_addr = (m_bytes - 3) / 2;
                m_wr = 1;
            end
            m_bytes++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            model_step();
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("rx_ready", rx_ready, m_ready());
            check("imem_we", imem_we, m_wr);
            if (m_wr) begin
                check("imem_addr", imem_addr, m_addr[ADDR_W-1:0]);
                check("imem_wdata", imem_wdata, m_data);
            end
            if (imem_we === 1'b1) begin
                wr_addr_q.push_back(int'(imem_addr));
                wr_data_q.push_back(imem_wdata);
                last_we_cyc = cyc;
            end
            check("cpu_reset", cpu_reset, (m_mode != M_RUN));
            check("load_done", load_done, (m_mode == M_RUN));
            check("load_error", load_error, (m_mode == M_ERR));
            if (rx_valid && rx_ready) last_acc_cyc = cyc;
            if (prev_cpu_reset && !cpu_reset) fall_cyc = cyc;
            prev_cpu_reset = cpu_reset;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        bit ok = 0;
        bit rdy;
        repeat ($urandom_range(0, maxgap)) begin
            rx_data = 8'($urandom);
            @(posedge clk); #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            rdy = rx_ready;
            @(posedge clk); #1;
            ok = rdy;
        end
        rx_valid = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL handshake: byte %0h not accepted within 50 cycles", b);
        end
    endtask

    task automatic load_stream(input int n, input logic [15:0] w[DEPTH], input int gap);
        send_byte(8'(n >> 8), gap);
        send_byte(8'(n), gap);
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                send_byte(w[i][15:8], gap);
                send_byte(w[i][7:0], gap);
            end
        end
        idle(4);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_writes(input string name, input int n, input logic [15:0] w[DEPTH]);
        check({name, "_count"}, wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check({name, "_addr"}, wr_addr_q[i], i);
            check({name, "_data"}, wr_data_q[i], w[i]);
        end
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        #1;
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, 4'h0);
        check("rst_wdata", imem_wdata, 16'h0000);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_done", load_done, 1'b0);
        check("rst_error", load_error, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Two-word load, back to back.
        clear_log();
        words[0] = 16'h1234; words[1] = 16'hABCD;
        load_stream(2, words, 0);
        check("t1_nwr", wr_addr_q.size(), 2);
        check("t1_w0", {wr_addr_q[0][15:0], wr_data_q[0]}, 32'h0000_1234);
        check("t1_w1", {wr_addr_q[1][15:0], wr_data_q[1]}, 32'h0001_ABCD);
        check("t1_fall_lat", fall_cyc - last_we_cyc, 1);
        check("t1_done", load_done, 1'b1);

        // Same stream with random gaps.
        do_reload();
        clear_log();
        load_stream(2, words, 3);
        check_writes("t2", 2, words);

        // Oversized count, then recovery.
        do_reload();
        clear_log();
        load_stream(17, words, 1);
        check("t3_error", load_error, 1'b1);
        check("t3_cpu_reset", cpu_reset, 1'b1);
        check("t3_nwr", wr_addr_q.size(), 0);
        do_reload();
        words[0] = 16'h5A5A;
        load_stream(1, words, 1);
        check("t3_w0", {wr_addr_q[0][15:0], wr_data_q[0]}, 32'h0000_5A5A);
        check("t3_done", load_done, 1'b1);

        // Empty program.
        do_reload();
        clear_log();
        load_stream(0, words, 2);
        check("t4_nwr", wr_addr_q.size(), 0);
        check("t4_fall_lat", fall_cyc - last_acc_cyc, 1);
        check("t4_done", load_done, 1'b1);

        // Full-depth load, reload in RUN, then single word to address 0.
        do_reload();
        clear_log();
        for (int i = 0; i < DEPTH; i++) words[i] = 16'($urandom);
        load_stream(DEPTH, words, 1);
        check_writes("t5", DEPTH, words);
        check("t5_last_addr", wr_addr_q[DEPTH-1], 15);
        do_reload();
        check("t5_reload_cpu_reset", cpu_reset, 1'b1);
        check("t5_reload_done", load_done, 1'b0);
        clear_log();
        words[0] = 16'hC0DE;
        load_stream(1, words, 0);
        check("t5_w0", {wr_addr_q[0][15:0], wr_data_q[0]}, 32'h0000_C0DE);

        // Async reset mid-load, then a fresh stream.
        do_reload();
        clear_log();
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hAB, 0);
        #2 reset = 1'b1;
        #1;
        check("t6_we", imem_we, 1'b0);
        check("t6_addr", imem_addr, 4'h0);
        check("t6_wdata", imem_wdata, 16'h0000);
        check("t6_cpu_reset", cpu_reset, 1'b1);
        check("t6_rx_ready", rx_ready, 1'b1);
        @(posedge clk); #1 reset = 1'b0;
        clear_log();
        words[0] = 16'h1234; words[1] = 16'hABCD;
        load_stream(2, words, 1);
        check_writes("t6", 2, words);

        // Random programs, one with a reload colliding with a byte handshake.
        for (int it = 0; it < 6; it++) begin
            do_reload();
            if (it == 2) begin
                send_byte(8'h00, 0);
                rx_valid = 1'b1; rx_data = 8'h00; reload = 1'b1;
                @(posedge clk); #1;
                rx_valid = 1'b0; reload = 1'b0;
            end
            clear_log();
            n = $urandom_range(0, 17);
            for (int i = 0; i < DEPTH; i++) words[i] = 16'($urandom);
            load_stream(n, words, 3);
            check_writes("rnd", (n <= DEPTH) ? n : 0, words);
            check("rnd_done", load_done, (n <= DEPTH));
            check("rnd_error", load_error, (n > DEPTH));
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
